// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle control unit: FSM states, datapath mux selects,
// ALU operations, MIPS opcode/funct encodings and the instruction class record
// passed from the decoder to the FSM.
package multicycle_control_unit_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} cu_state_t;

  typedef enum logic [1:0] {PC_ADD4, PC_JUMP, PC_JR, PC_BRANCH} pcsrc_t;
  typedef enum logic [1:0] {ALUSRC_RDAT2, ALUSRC_SHAMT, ALUSRC_EXT} alusrc_t;
  typedef enum logic {EXT_ZERO, EXT_SIGN} extop_t;
  typedef enum logic [1:0] {WM_R31, WM_LUI, WM_DATA, WM_ALUOUT} wmux_t;
  typedef enum logic {ZSEL_EQ, ZSEL_NE} zero_sel_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
    OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B
  } opcode_t;

  typedef enum logic [FN_W-1:0] {
    FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
    FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
    FN_OR  = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  // Instruction class flags the FSM sequences on.
  typedef struct packed {
    logic      is_branch;
    zero_sel_t zsel;
    logic      is_j;
    logic      is_jr;
    logic      is_lw;
    logic      is_sw;
    logic      is_trap_op;
    logic      rf_write;
  } iclass_t;

endpackage

// File: rtl/multicycle_control_unit_mc_decode.sv
// Purely combinational instruction decode: static datapath controls, register
// selects, field extraction and instruction class for the FSM.
// Ports: instr in; alu_op, alu_src, ext_op, w_mux, pc_src, wsel, rsel1, rsel2,
// imm16, shamt, j_addr26, cls out.
module multicycle_control_unit_mc_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic [WORD_W-1:0] instr,
  output aluop_t            alu_op,
  output alusrc_t           alu_src,
  output extop_t            ext_op,
  output wmux_t             w_mux,
  output pcsrc_t            pc_src,
  output logic [REG_AW-1:0] wsel,
  output logic [REG_AW-1:0] rsel1,
  output logic [REG_AW-1:0] rsel2,
  output logic [15:0]       imm16,
  output logic [4:0]        shamt,
  output logic [25:0]       j_addr26,
  output iclass_t           cls
);

  opcode_t    op;
  funct_t     fn;
  logic [4:0] rs, rt, rd;

  assign op       = opcode_t'(instr[31:26]);
  assign fn       = funct_t'(instr[5:0]);
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign imm16    = instr[15:0];
  assign j_addr26 = instr[25:0];
  assign rsel1    = REG_AW'(rs);

  // Static decode; unknown opcodes/functs fall through as a non-writing NOP.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_src = ALUSRC_EXT;
    ext_op  = EXT_SIGN;
    w_mux   = WM_ALUOUT;
    pc_src  = PC_ADD4;
    wsel    = REG_AW'(rt);
    rsel2   = '0;
    cls     = '0;
    unique case (op)
      OP_RTYPE: begin
        alu_src      = ALUSRC_RDAT2;
        wsel         = REG_AW'(rd);
        rsel2        = REG_AW'(rt);
        cls.rf_write = 1'b1;
        unique case (fn)
          FN_SLL:  begin alu_op = ALU_SLL; alu_src = ALUSRC_SHAMT; end
          FN_SRL:  begin alu_op = ALU_SRL; alu_src = ALUSRC_SHAMT; end
          FN_JR:   begin pc_src = PC_JR; cls.is_jr = 1'b1; cls.rf_write = 1'b0; end
          FN_ADD:  begin alu_op = ALU_ADD; cls.is_trap_op = 1'b1; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUB:  begin alu_op = ALU_SUB; cls.is_trap_op = 1'b1; end
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: cls.rf_write = 1'b0;
        endcase
      end
      OP_J:     begin pc_src = PC_JUMP; cls.is_j = 1'b1; end
      OP_JAL: begin
        pc_src       = PC_JUMP;
        w_mux        = WM_R31;
        wsel         = REG_AW'(LINK_REG);
        cls.rf_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu_op        = ALU_SUB;
        alu_src       = ALUSRC_RDAT2;
        rsel2         = REG_AW'(rt);
        pc_src        = PC_BRANCH;
        cls.is_branch = 1'b1;
        cls.zsel      = (op == OP_BNE) ? ZSEL_NE : ZSEL_EQ;
      end
      OP_ADDI:  begin cls.rf_write = 1'b1; cls.is_trap_op = 1'b1; end
      OP_ADDIU: cls.rf_write = 1'b1;
      OP_SLTI:  begin alu_op = ALU_SLT;  cls.rf_write = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; cls.rf_write = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND; ext_op = EXT_ZERO; cls.rf_write = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;  ext_op = EXT_ZERO; cls.rf_write = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR; ext_op = EXT_ZERO; cls.rf_write = 1'b1; end
      OP_LUI:   begin w_mux = WM_LUI; ext_op = EXT_ZERO; cls.rf_write = 1'b1; end
      OP_LW:    begin w_mux = WM_DATA; cls.is_lw = 1'b1; cls.rf_write = 1'b1; end
      OP_SW:    begin rsel2 = REG_AW'(rt); cls.is_sw = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with cache
// handshakes, overflow trap, sticky halt and memory-wait timeout.
// Ports: CLK, RST (async, active-high); instr, i_hit, d_hit, zero_f, overflow_f in;
// strobes i_ren, ir_wen, d_ren, d_wen, pc_wen, rf_wen; decoded controls pc_src,
// alu_op, alu_src, ext_op, w_mux, wsel, rsel1, rsel2, imm16, shamt, j_addr26;
// status halt, timeout, state.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned       WORD_W      = 32,
  parameter int unsigned       REG_AW      = 5,
  parameter int unsigned       LINK_REG    = 31,
  parameter logic [WORD_W-1:0] HALT_INSTR  = WORD_W'(32'hFFFF_FFFF),
  parameter bit                OVF_TRAP_EN = 1'b1,
  parameter int unsigned       MEM_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] instr,
  input  logic              i_hit,
  input  logic              d_hit,
  input  logic              zero_f,
  input  logic              overflow_f,
  output logic              i_ren,
  output logic              ir_wen,
  output logic              d_ren,
  output logic              d_wen,
  output logic              pc_wen,
  output pcsrc_t            pc_src,
  output aluop_t            alu_op,
  output alusrc_t           alu_src,
  output extop_t            ext_op,
  output wmux_t             w_mux,
  output logic [REG_AW-1:0] wsel,
  output logic [REG_AW-1:0] rsel1,
  output logic [REG_AW-1:0] rsel2,
  output logic              rf_wen,
  output logic [15:0]       imm16,
  output logic [4:0]        shamt,
  output logic [25:0]       j_addr26,
  output logic              halt,
  output logic              timeout,
  output cu_state_t         state
);

  localparam logic [WAIT_W-1:0] TO_LIM = WAIT_W'(MEM_TIMEOUT);

  cu_state_t         state_next;
  iclass_t           cls;
  pcsrc_t            dec_pc_src;
  logic              ovf_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              to_reached;
  logic              waiting;
  logic              to_set;
  logic              taken;
  logic              trap;

  multicycle_control_unit_mc_decode #(
    .WORD_W  (WORD_W),
    .REG_AW  (REG_AW),
    .LINK_REG(LINK_REG)
  ) u_decode (
    .instr   (instr),
    .alu_op  (alu_op),
    .alu_src (alu_src),
    .ext_op  (ext_op),
    .w_mux   (w_mux),
    .pc_src  (dec_pc_src),
    .wsel    (wsel),
    .rsel1   (rsel1),
    .rsel2   (rsel2),
    .imm16   (imm16),
    .shamt   (shamt),
    .j_addr26(j_addr26),
    .cls     (cls)
  );

  assign taken  = (cls.zsel == ZSEL_EQ) ? zero_f : !zero_f;
  assign pc_src = (cls.is_branch && !taken) ? PC_ADD4 : dec_pc_src;
  assign trap   = OVF_TRAP_EN && ovf_q && cls.is_trap_op;

  // The count that this wait cycle would reach; a hit on that cycle wins.
  assign wait_inc   = wait_cnt + WAIT_W'(1);
  assign to_reached = (MEM_TIMEOUT != 0) && (wait_inc == TO_LIM);

  // Next state and strobes; all strobes are forced low while reset is held.
  always_comb begin
    state_next = state;
    i_ren      = 1'b0;
    ir_wen     = 1'b0;
    d_ren      = 1'b0;
    d_wen      = 1'b0;
    pc_wen     = 1'b0;
    rf_wen     = 1'b0;
    waiting    = 1'b0;
    to_set     = 1'b0;
    unique case (state)
      FETCH: begin
        i_ren = 1'b1;
        if (i_hit) begin
          ir_wen     = 1'b1;
          state_next = DECODE;
        end else begin
          waiting = 1'b1;
          if (to_reached) begin
            to_set     = 1'b1;
            state_next = HALT;
          end
        end
      end
      DECODE: state_next = (instr == HALT_INSTR) ? HALT : EXEC;
      EXEC: begin
        if (cls.is_branch || cls.is_j || cls.is_jr) begin
          pc_wen     = 1'b1;
          state_next = FETCH;
        end else if (cls.is_lw || cls.is_sw) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        d_ren = cls.is_lw;
        d_wen = cls.is_sw;
        if (d_hit) begin
          if (cls.is_lw) begin
            state_next = WB;
          end else begin
            pc_wen     = 1'b1;
            state_next = FETCH;
          end
        end else begin
          waiting = 1'b1;
          if (to_reached) begin
            to_set     = 1'b1;
            state_next = HALT;
          end
        end
      end
      WB: begin
        if (trap) begin
          state_next = HALT;
        end else begin
          rf_wen     = cls.rf_write;
          pc_wen     = 1'b1;
          state_next = FETCH;
        end
      end
      HALT:    ;
      default: state_next = FETCH;
    endcase
    if (RST) begin
      i_ren  = 1'b0;
      ir_wen = 1'b0;
      d_ren  = 1'b0;
      d_wen  = 1'b0;
      pc_wen = 1'b0;
      rf_wen = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FETCH;
    else     state <= state_next;
  end

  // Wait counter, captured overflow, sticky halt and timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
      ovf_q    <= 1'b0;
      halt     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_inc : '0;
      if (state == EXEC)      ovf_q   <= overflow_f;
      if (state_next == HALT) halt    <= 1'b1;
      if (to_set)             timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (MEM_TIMEOUT=4).
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;  // addu $3,$1,$2
  localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add  $3,$1,$2
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;  // beq  $1,$2,4
  localparam logic [31:0] I_LW   = 32'h8C25_0008;  // lw   $5,8($1)
  localparam logic [31:0] I_SW   = 32'hAC25_0008;  // sw   $5,8($1)
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_UNK  = 32'hFC00_0000;
  localparam logic [31:0] I_HALT = 32'hFFFF_FFFF;

  logic        CLK, RST;
  logic [31:0] instr;
  logic        i_hit, d_hit, zero_f, overflow_f;
  logic        i_ren, ir_wen, d_ren, d_wen, pc_wen, rf_wen, halt, timeout;
  pcsrc_t      pc_src;
  aluop_t      alu_op;
  alusrc_t     alu_src;
  extop_t      ext_op;
  wmux_t       w_mux;
  logic [4:0]  wsel, rsel1, rsel2, shamt;
  logic [15:0] imm16;
  logic [25:0] j_addr26;
  cu_state_t   state;

  int n_chk  = 0;
  int n_fail = 0;
  int r_cyc, r_pcw, r_rfw, r_irw, r_dren, r_dwen, r_bad;
  pcsrc_t     r_pcsrc;
  wmux_t      r_wmux;
  logic [4:0] r_wsel;

  multicycle_control_unit #(.MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .instr(instr), .i_hit(i_hit), .d_hit(d_hit),
    .zero_f(zero_f), .overflow_f(overflow_f), .i_ren(i_ren), .ir_wen(ir_wen),
    .d_ren(d_ren), .d_wen(d_wen), .pc_wen(pc_wen), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op), .w_mux(w_mux),
    .wsel(wsel), .rsel1(rsel1), .rsel2(rsel2), .rf_wen(rf_wen), .imm16(imm16),
    .shamt(shamt), .j_addr26(j_addr26), .halt(halt), .timeout(timeout),
    .state(state)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {26'b0, i_ren, ir_wen, d_ren, d_wen, pc_wen, rf_wen};
  endfunction

  // Asserts reset, checks reset values, releases at posedge+1 (first FETCH cycle).
  task automatic do_reset();
    RST = 1'b1;
    #2;
    check("rst_state", 32'(state), 32'(FETCH));
    check("rst_strobes", strobes(), 32'h0);
    check("rst_halt_timeout", {30'b0, halt, timeout}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Runs one instruction from a FETCH cycle until FETCH or HALT is re-entered.
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic ovf,
                           input int dhit_delay);
    int mem_k;
    mem_k = 0;
    instr = ins; i_hit = 1'b1; zero_f = z;
    r_cyc = 0; r_pcw = 0; r_rfw = 0; r_irw = 0; r_dren = 0; r_dwen = 0; r_bad = 0;
    r_pcsrc = PC_ADD4; r_wmux = WM_ALUOUT; r_wsel = '0;
    for (int k = 0; k < 40; k++) begin
      overflow_f = (state == EXEC) ? ovf : 1'b0;
      d_hit      = (state == MEM) && (mem_k >= dhit_delay);
      if (state == MEM) mem_k++;
      #3;
      r_cyc++;
      if (ir_wen) r_irw++;
      if (pc_wen) begin r_pcw++; r_pcsrc = pc_src; end
      if (rf_wen) begin
        r_rfw++; r_wsel = wsel; r_wmux = w_mux;
        if (state != WB) r_bad++;
      end
      if (d_ren) r_dren++;
      if (d_wen) r_dwen++;
      @(posedge CLK);
      #1;
      if (state == FETCH || state == HALT) break;
    end
    d_hit = 1'b0; overflow_f = 1'b0;
  endtask

  initial begin
    int bad;
    RST = 1'b0; instr = '0; i_hit = 1'b0; d_hit = 1'b0; zero_f = 1'b0; overflow_f = 1'b0;
    #1;
    do_reset();

    run_instr(I_ADDU, 1'b0, 1'b0, 0);
    check("addu_cycles", 32'(r_cyc), 32'd4);
    check("addu_irwen", 32'(r_irw), 32'd1);
    check("addu_pcwen", 32'(r_pcw), 32'd1);
    check("addu_rfwen", 32'(r_rfw), 32'd1);
    check("addu_rfwen_outside_wb", 32'(r_bad), 32'd0);
    check("addu_wsel", 32'(r_wsel), 32'd3);
    check("addu_wmux", 32'(r_wmux), 32'(WM_ALUOUT));
    check("addu_pcsrc", 32'(r_pcsrc), 32'(PC_ADD4));
    check("addu_end_state", 32'(state), 32'(FETCH));

    run_instr(I_BEQ, 1'b1, 1'b0, 0);
    check("beq_t_cycles", 32'(r_cyc), 32'd3);
    check("beq_t_pcwen", 32'(r_pcw), 32'd1);
    check("beq_t_pcsrc", 32'(r_pcsrc), 32'(PC_BRANCH));
    check("beq_t_rfwen", 32'(r_rfw), 32'd0);
    check("beq_rsel2", 32'(rsel2), 32'd2);

    run_instr(I_BEQ, 1'b0, 1'b0, 0);
    check("beq_nt_cycles", 32'(r_cyc), 32'd3);
    check("beq_nt_pcsrc", 32'(r_pcsrc), 32'(PC_ADD4));
    check("beq_nt_rfwen", 32'(r_rfw), 32'd0);

    run_instr(I_LW, 1'b0, 1'b0, 3);
    check("lw_cycles", 32'(r_cyc), 32'd8);
    check("lw_dren_cycles", 32'(r_dren), 32'd4);
    check("lw_rfwen", 32'(r_rfw), 32'd1);
    check("lw_wsel", 32'(r_wsel), 32'd5);
    check("lw_wmux", 32'(r_wmux), 32'(WM_DATA));
    check("lw_pcwen", 32'(r_pcw), 32'd1);
    check("lw_rsel2", 32'(rsel2), 32'd0);
    check("lw_imm16", 32'(imm16), 32'd8);

    run_instr(I_SW, 1'b0, 1'b0, 0);
    check("sw_cycles", 32'(r_cyc), 32'd4);
    check("sw_dwen", 32'(r_dwen), 32'd1);
    check("sw_rfwen", 32'(r_rfw), 32'd0);
    check("sw_pcwen", 32'(r_pcw), 32'd1);
    check("sw_rsel2", 32'(rsel2), 32'd5);

    run_instr(I_J, 1'b0, 1'b0, 0);
    check("j_cycles", 32'(r_cyc), 32'd3);
    check("j_pcsrc", 32'(r_pcsrc), 32'(PC_JUMP));
    check("j_rfwen", 32'(r_rfw), 32'd0);
    check("j_addr26", 32'(j_addr26), 32'h10);

    run_instr(I_JAL, 1'b0, 1'b0, 0);
    check("jal_cycles", 32'(r_cyc), 32'd4);
    check("jal_rfwen", 32'(r_rfw), 32'd1);
    check("jal_wsel", 32'(r_wsel), 32'd31);
    check("jal_wmux", 32'(r_wmux), 32'(WM_R31));
    check("jal_pcsrc", 32'(r_pcsrc), 32'(PC_JUMP));

    run_instr(I_UNK, 1'b0, 1'b0, 0);
    check("unk_cycles", 32'(r_cyc), 32'd4);
    check("unk_rfwen", 32'(r_rfw), 32'd0);
    check("unk_pcwen", 32'(r_pcw), 32'd1);
    check("unk_pcsrc", 32'(r_pcsrc), 32'(PC_ADD4));

    run_instr(I_ADDU, 1'b0, 1'b1, 0);
    check("addu_ovf_rfwen", 32'(r_rfw), 32'd1);
    check("addu_ovf_state", 32'(state), 32'(FETCH));
    check("addu_ovf_halt", 32'(halt), 32'd0);

    run_instr(I_ADD, 1'b0, 1'b1, 0);
    check("add_ovf_cycles", 32'(r_cyc), 32'd4);
    check("add_ovf_rfwen", 32'(r_rfw), 32'd0);
    check("add_ovf_pcwen", 32'(r_pcw), 32'd0);
    check("add_ovf_state", 32'(state), 32'(HALT));
    check("add_ovf_halt", 32'(halt), 32'd1);
    do_reset();

    run_instr(I_HALT, 1'b0, 1'b0, 0);
    check("halt_cycles", 32'(r_cyc), 32'd2);
    check("halt_state", 32'(state), 32'(HALT));
    check("halt_flag", 32'(halt), 32'd1);
    bad = 0;
    i_hit = 1'b1; d_hit = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (halt !== 1'b1 || state != HALT || strobes() != 32'h0) bad++;
      @(posedge CLK);
      #1;
    end
    check("halt_absorbing", 32'(bad), 32'd0);
    do_reset();

    // FETCH miss for four cycles times out.
    instr = I_ADDU; i_hit = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    #2;
    check("ito_before_state", 32'(state), 32'(FETCH));
    check("ito_before_timeout", 32'(timeout), 32'd0);
    @(posedge CLK); #1;
    check("ito_timeout", 32'(timeout), 32'd1);
    check("ito_halt", 32'(halt), 32'd1);
    check("ito_state", 32'(state), 32'(HALT));
    do_reset();

    // Hit on the fourth cycle wins over the timeout.
    instr = I_ADDU; i_hit = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    i_hit = 1'b1;
    #2;
    check("ihit4_irwen", 32'(ir_wen), 32'd1);
    @(posedge CLK); #1;
    check("ihit4_state", 32'(state), 32'(DECODE));
    check("ihit4_timeout", 32'(timeout), 32'd0);
    do_reset();

    run_instr(I_SW, 1'b0, 1'b0, 100);
    check("mto_cycles", 32'(r_cyc), 32'd7);
    check("mto_dwen", 32'(r_dwen), 32'd4);
    check("mto_state", 32'(state), 32'(HALT));
    check("mto_timeout", 32'(timeout), 32'd1);
    do_reset();

    // Reset in the middle of a load aborts it.
    instr = I_LW; i_hit = 1'b1; d_hit = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    #2;
    check("abort_in_mem", 32'(state), 32'(MEM));
    check("abort_dren", 32'(d_ren), 32'd1);
    do_reset();
    #2;
    check("abort_after_state", 32'(state), 32'(FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
